// File: rtl/approx_mult_error_monitor.sv
// approx_mult_error_monitor: exact-vs-approx product error statistics over a run of samples
module approx_mult_error_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [W-1:0]       y,
  input  logic [2*W-1:0]     z_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_ed,
  output logic               sat,
  output logic [2*W-1:0]     max_ed,
  output logic [W-1:0]       max_x,
  output logic [W-1:0]       max_y
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] num_lat, accepted;
  logic s1_v, s2_v, acc, take;
  logic [W-1:0] s1_x, s1_y, s2_x, s2_y;
  logic [2*W-1:0] s1_z, s2_ed, exact;
  logic [ACC_W:0] sum_nx;
  assign in_ready = (state == RUN) && (accepted < num_lat);
  assign acc      = in_valid && in_ready;
  assign take     = start && (state == IDLE || state == DONE);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign exact    = {{W{1'b0}}, s1_x} * {{W{1'b0}}, s1_y};
  assign sum_nx   = {1'b0, sum_ed} + {{(ACC_W+1-2*W){1'b0}}, s2_ed};
  always_comb begin
    state_nx = state;
    if (take)
      state_nx = (num_samples == '0) ? DONE : RUN;
    else if (state == RUN && acc && accepted == num_lat - 1'b1)
      state_nx = DRAIN;
    else if (state == DRAIN && !s1_v)
      state_nx = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num_lat   <= '0;
      accepted  <= '0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_z      <= '0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_ed     <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      sat       <= 1'b0;
      max_ed    <= '0;
      max_x     <= '0;
      max_y     <= '0;
    end else begin
      state <= state_nx;
      s1_v  <= acc;
      s2_v  <= s1_v;
      if (acc) begin
        s1_x <= x;
        s1_y <= y;
        s1_z <= z_approx;
      end
      if (s1_v) begin
        s2_x  <= s1_x;
        s2_y  <= s1_y;
        s2_ed <= (exact >= s1_z) ? exact - s1_z : s1_z - exact;
      end
      if (take) begin
        num_lat   <= num_samples;
        accepted  <= '0;
        err_count <= '0;
        sum_ed    <= '0;
        sat       <= 1'b0;
        max_ed    <= '0;
        max_x     <= '0;
        max_y     <= '0;
      end else begin
        if (acc) accepted <= accepted + 1'b1;
        if (s2_v) begin
          err_count <= err_count + CNT_W'(s2_ed != '0);
          sum_ed    <= sum_nx[ACC_W] ? '1 : sum_nx[ACC_W-1:0];
          if (sum_nx[ACC_W]) sat <= 1'b1;
          // strict compare keeps the earliest sample on a tie
          if (s2_ed > max_ed) begin
            max_ed <= s2_ed;
            max_x  <= s2_x;
            max_y  <= s2_y;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// tb_approx_mult_error_monitor: directed vectors against hand-computed error statistics
module tb_approx_mult_error_monitor;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [15:0] num_samples = 0, z_approx = 0;
  logic [7:0] x = 0, y = 0;
  logic in_ready, busy, done, sat, in_ready_b, busy_b, done_b, sat_b;
  logic [15:0] err_count, err_count_b, max_ed, max_ed_b;
  logic [31:0] sum_ed;
  logic [16:0] sum_ed_b;
  logic [7:0] max_x, max_y, max_x_b, max_y_b;
  int total = 0, bad = 0, cyc = 0, t0, n;

  approx_mult_error_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed), .sat(sat),
    .max_ed(max_ed), .max_x(max_x), .max_y(max_y));

  approx_mult_error_monitor #(.ACC_W(17)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_b), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy_b), .done(done_b), .err_count(err_count_b), .sum_ed(sum_ed_b), .sat(sat_b),
    .max_ed(max_ed_b), .max_x(max_x_b), .max_y(max_y_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int ns);
    start = 1;
    num_samples = 16'(ns);
    tick();
    start = 0;
  endtask

  task automatic send(input int xv, input int yv, input int zv, input int gap);
    int k;
    in_valid = 0;
    repeat (gap) tick();
    x = 8'(xv);
    y = 8'(yv);
    z_approx = 16'(zv);
    in_valid = 1;
    for (k = 0; k < 20 && !in_ready; k++) tick();
    if (!in_ready) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 50) begin
      tick();
      c++;
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", err_count, 0);
    chk("rst_sum", sum_ed, 0);
    chk("rst_max", max_ed, 0);
    rst = 0;
    tick();

    // exact products
    pulse_start(4);
    t0 = cyc;
    chk("t1_busy", busy, 1);
    send(3, 5, 15, 0);
    send(255, 255, 65025, 0);
    send(0, 200, 0, 0);
    send(17, 1, 17, 0);
    wait_done(n);
    chk("t1_latency", cyc - t0, 6);
    chk("t1_err", err_count, 0);
    chk("t1_sum", sum_ed, 0);
    chk("t1_max", max_ed, 0);
    chk("t1_mx", max_x, 0);
    chk("t1_my", max_y, 0);
    chk("t1_ready", in_ready, 0);

    // both error signs
    pulse_start(3);
    chk("t2_done_drop", done, 0);
    send(3, 5, 14, 0);
    send(3, 5, 20, 0);
    send(2, 2, 4, 0);
    wait_done(n);
    chk("t2_err", err_count, 2);
    chk("t2_sum", sum_ed, 6);
    chk("t2_max", max_ed, 5);
    chk("t2_mx", max_x, 3);
    chk("t2_my", max_y, 5);

    // tie with bubbles
    pulse_start(2);
    send(4, 4, 10, 3);
    send(2, 5, 4, 3);
    wait_done(n);
    chk("t3_lat", n, 2);
    chk("t3_max", max_ed, 6);
    chk("t3_mx", max_x, 4);
    chk("t3_my", max_y, 4);
    chk("t3_err", err_count, 2);
    chk("t3_sum", sum_ed, 12);

    // saturation on the 17-bit accumulator
    pulse_start(3);
    repeat (3) send(255, 255, 0, 0);
    wait_done(n);
    chk("t4_sum17", sum_ed_b, 131071);
    chk("t4_sat17", sat_b, 1);
    chk("t4_max17", max_ed_b, 65025);
    chk("t4_sum32", sum_ed, 195075);
    chk("t4_sat32", sat, 0);

    // zero-length run
    pulse_start(0);
    chk("t5_done", done, 1);
    chk("t5_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err_count, 0);
    chk("t5_sum", sum_ed, 0);
    chk("t5_sat17", sat_b, 0);

    // start while busy is ignored
    pulse_start(2);
    send(1, 1, 3, 0);
    pulse_start(5);
    chk("t5_busy_start", busy, 1);
    send(1, 1, 3, 0);
    wait_done(n);
    chk("t5b_done", done, 1);
    chk("t5b_err", err_count, 2);
    chk("t5b_sum", sum_ed, 4);

    // reset mid-run
    pulse_start(5);
    send(3, 5, 0, 0);
    send(3, 5, 0, 0);
    tick();
    chk("t6_pre_err", err_count, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", in_ready, 0);
    chk("t6_err", err_count, 0);
    chk("t6_sum", sum_ed, 0);
    chk("t6_max", max_ed, 0);
    chk("t6_mx", max_x, 0);
    repeat (3) tick();
    chk("t6_no_inflight", err_count, 0);
    pulse_start(1);
    send(3, 3, 8, 0);
    wait_done(n);
    chk("t6_done2", done, 1);
    chk("t6_err2", err_count, 1);
    chk("t6_sum2", sum_ed, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
